// File: rtl/ntt_stage_scheduler.sv
// ntt_stage_scheduler
//   Walks the in-place radix-2 NTT over all LOG_N stages. It issues one butterfly per
//   cycle as two coefficient addresses and a twiddle index. After each stage it leaves a
//   gap of BF_LATENCY cycles so the butterfly pipeline can write back. It then pulses done.
//
// Ports
//   clk      in   clock, all logic on posedge
//   rst      in   synchronous active-high reset
//   start    in   begin a transform (sampled in IDLE only)
//   inverse  in   latched with start: 0 = stages 0..LOG_N-1, 1 = LOG_N-1..0
//   stall    in   holds the current butterfly while in RUN
//   valid    out  addr_a/addr_b/tw_idx/stage carry a butterfly this cycle
//   addr_a   out  upper operand address
//   addr_b   out  lower operand address (addr_a + 2^stage)
//   tw_idx   out  twiddle ROM index
//   stage    out  current stage number
//   busy     out  high in RUN, DRAIN and DONE
//   done     out  one-cycle pulse at the end of a transform
module ntt_stage_scheduler #(
    parameter int LOG_N      = 3,
    parameter int BF_LATENCY = 2,
    localparam int SW        = (LOG_N > 2) ? $clog2(LOG_N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inverse,
    input  logic             stall,
    output logic             valid,
    output logic [LOG_N-1:0] addr_a,
    output logic [LOG_N-1:0] addr_b,
    output logic [LOG_N-2:0] tw_idx,
    output logic [SW-1:0]    stage,
    output logic             busy,
    output logic             done
);

    localparam int JW = LOG_N - 1;
    localparam int DW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY + 1) : 1;

    localparam logic [JW-1:0] J_LAST     = '1;
    localparam logic [SW-1:0] STAGE_LAST = SW'(LOG_N - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'((BF_LATENCY > 0) ? BF_LATENCY - 1 : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [JW-1:0] j_q, j_d;
    logic [SW-1:0] stage_q, stage_d;
    logic          inv_q, inv_d;
    logic [DW-1:0] cnt_q, cnt_d;

    logic          last_stage;
    logic [SW-1:0] next_stage;

    // grp*2*half + pos == j + grp*half == j + (j with the low s bits cleared)
    function automatic logic [LOG_N-1:0] calc_addr_a(input logic [JW-1:0] j,
                                                      input logic [SW-1:0] s);
        logic [LOG_N-1:0] jx;
        logic [LOG_N-1:0] mask;
        jx   = {1'b0, j};
        mask = (LOG_N'(1) << s) - LOG_N'(1);
        return jx + (jx & ~mask);
    endfunction

    function automatic logic [LOG_N-2:0] calc_tw(input logic [JW-1:0] j,
                                                 input logic [SW-1:0] s);
        logic [LOG_N-1:0] jx;
        logic [LOG_N-1:0] mask;
        logic [LOG_N-1:0] tmp;
        logic [SW-1:0]    sh;
        jx   = {1'b0, j};
        mask = (LOG_N'(1) << s) - LOG_N'(1);
        sh   = STAGE_LAST - s;
        // pos < 2^s, so pos << (LOG_N-1-s) always fits in LOG_N-1 bits
        tmp  = (jx & mask) << sh;
        return tmp[LOG_N-2:0];
    endfunction

    assign last_stage = (stage_q == (inv_q ? '0 : STAGE_LAST));
    assign next_stage = inv_q ? (stage_q - SW'(1)) : (stage_q + SW'(1));

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        stage_d = stage_q;
        inv_d   = inv_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    inv_d   = inverse;
                    stage_d = inverse ? STAGE_LAST : '0;
                    j_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (j_q == J_LAST) begin
                        j_d = '0;
                        if (BF_LATENCY > 0) begin
                            cnt_d   = DRAIN_LAST;
                            state_d = ST_DRAIN;
                        end else if (last_stage) begin
                            state_d = ST_DONE;
                        end else begin
                            stage_d = next_stage;
                        end
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    if (last_stage) begin
                        state_d = ST_DONE;
                    end else begin
                        stage_d = next_stage;
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q - DW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
            cnt_q   <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            addr_a  <= '0;
            addr_b  <= '0;
            tw_idx  <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            stage_q <= stage_d;
            inv_q   <= inv_d;
            cnt_q   <= cnt_d;
            valid   <= (state_d == ST_RUN);
            busy    <= (state_d != ST_IDLE);
            done    <= (state_d == ST_DONE);
            if (state_d == ST_RUN) begin
                addr_a <= calc_addr_a(j_d, stage_d);
                addr_b <= calc_addr_a(j_d, stage_d) + (LOG_N'(1) << stage_d);
                tw_idx <= calc_tw(j_d, stage_d);
            end
        end
    end

    assign stage = stage_q;

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
module tb_ntt_stage_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, inverse, stall;
    logic       valid, busy, done;
    logic [2:0] addr_a, addr_b;
    logic [1:0] tw_idx;
    logic [1:0] stage;

    logic       start0;
    logic       valid0, busy0, done0;
    logic [2:0] addr_a0, addr_b0;
    logic [1:0] tw_idx0;
    logic [1:0] stage0;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected butterflies per stage, hand-derived for N=8
    logic [2:0] ta  [3][4] = '{'{3'd0, 3'd2, 3'd4, 3'd6},
                               '{3'd0, 3'd1, 3'd4, 3'd5},
                               '{3'd0, 3'd1, 3'd2, 3'd3}};
    logic [2:0] tb_ [3][4] = '{'{3'd1, 3'd3, 3'd5, 3'd7},
                               '{3'd2, 3'd3, 3'd6, 3'd7},
                               '{3'd4, 3'd5, 3'd6, 3'd7}};
    logic [1:0] ttw [3][4] = '{'{2'd0, 2'd0, 2'd0, 2'd0},
                               '{2'd0, 2'd2, 2'd0, 2'd2},
                               '{2'd0, 2'd1, 2'd2, 2'd3}};

    always #5 clk = ~clk;

    ntt_stage_scheduler #(.LOG_N(3), .BF_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse), .stall(stall),
        .valid(valid), .addr_a(addr_a), .addr_b(addr_b), .tw_idx(tw_idx),
        .stage(stage), .busy(busy), .done(done)
    );

    ntt_stage_scheduler #(.LOG_N(3), .BF_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .inverse(1'b0), .stall(1'b0),
        .valid(valid0), .addr_a(addr_a0), .addr_b(addr_b0), .tw_idx(tw_idx0),
        .stage(stage0), .busy(busy0), .done(done0)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; inverse = 1'b0; stall = 1'b0; start0 = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({valid, busy, done} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset ctl: got v/b/d=%b want 000", {valid, busy, done});
        end
        n_cmp++;
        if ({addr_a, addr_b, tw_idx, stage} !== 10'd0) begin
            n_bad++;
            $display("FAIL reset data: got a=%0d b=%0d tw=%0d st=%0d want 0", addr_a, addr_b,
                     tw_idx, stage);
        end
        n_cmp++;
        if ({valid0, busy0, done0} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset lat0: got v/b/d=%b want 000", {valid0, busy0, done0});
        end
        next_cycle();
    endtask

    // Full transform; optional start pokes in cycles 5 and 19, and inverse toggles after start.
    task automatic test_sequence(input logic inv, input logic poke, input string tag);
        int         s, off;
        logic       ev, eb, ed;
        logic [1:0] es;
        for (int c = 0; c <= 20; c++) begin
            start   = (c == 0) || (poke && (c == 5 || c == 19));
            inverse = (c == 0) ? inv : ~inv;
            @(negedge clk);
            ev = 1'b0; s = 0; off = 0;
            if (c >= 1 && c <= 18) begin
                off = (c - 1) % 6;
                s   = inv ? 2 - (c - 1) / 6 : (c - 1) / 6;
                ev  = (off < 4);
            end
            eb = (c >= 1 && c <= 19);
            ed = (c == 19);
            n_cmp++;
            if ({valid, busy, done} !== {ev, eb, ed}) begin
                n_bad++;
                $display("FAIL %s c%0d v/b/d: got %b want %b", tag, c, {valid, busy, done},
                         {ev, eb, ed});
            end
            if (ev) begin
                es = s[1:0];
                n_cmp++;
                if ({stage, addr_a, addr_b, tw_idx} !== {es, ta[s][off], tb_[s][off], ttw[s][off]})
                begin
                    n_bad++;
                    $display("FAIL %s c%0d st/a/b/tw: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                             tag, c, stage, addr_a, addr_b, tw_idx, es, ta[s][off],
                             tb_[s][off], ttw[s][off]);
                end
            end
            next_cycle();
        end
        start = 1'b0;
        inverse = 1'b0;
    endtask

    task automatic test_stall;
        int   e, s, off;
        logic ev, ed;
        for (int c = 0; c <= 23; c++) begin
            start = (c == 0);
            stall = (c >= 2 && c <= 4);
            @(negedge clk);
            // Position in the stall-free timeline: j=1 is held for cycles 2..5
            e  = (c <= 2) ? c : (c <= 5) ? 2 : c - 3;
            ev = 1'b0; s = 0; off = 0;
            if (e >= 1 && e <= 18) begin
                off = (e - 1) % 6;
                s   = (e - 1) / 6;
                ev  = (off < 4);
            end
            ed = (c == 22);
            n_cmp++;
            if ({valid, done} !== {ev, ed}) begin
                n_bad++;
                $display("FAIL stall c%0d v/d: got %b want %b", c, {valid, done}, {ev, ed});
            end
            if (ev) begin
                n_cmp++;
                if ({addr_a, addr_b, tw_idx} !== {ta[s][off], tb_[s][off], ttw[s][off]}) begin
                    n_bad++;
                    $display("FAIL stall c%0d a/b/tw: got %0d/%0d/%0d want %0d/%0d/%0d", c,
                             addr_a, addr_b, tw_idx, ta[s][off], tb_[s][off], ttw[s][off]);
                end
            end
            next_cycle();
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c <= 11; c++) begin
            start = (c == 0) || (c == 10);
            rst   = (c == 8);
            @(negedge clk);
            if (c == 8) begin
                n_cmp++;
                if ({valid, addr_a, addr_b, tw_idx} !== {1'b1, 3'd1, 3'd3, 2'd2}) begin
                    n_bad++;
                    $display("FAIL rstmid c8: got v=%b a=%0d b=%0d tw=%0d want 1/1/3/2", valid,
                             addr_a, addr_b, tw_idx);
                end
            end
            if (c == 9 || c == 10) begin
                n_cmp++;
                if ({valid, busy, done, stage, addr_a} !== 8'd0) begin
                    n_bad++;
                    $display("FAIL rstmid c%0d: got v=%b b=%b d=%b st=%0d a=%0d want all 0", c,
                             valid, busy, done, stage, addr_a);
                end
            end
            if (c == 11) begin
                n_cmp++;
                if ({valid, stage, addr_a, addr_b, tw_idx} !== {1'b1, 2'd0, 3'd0, 3'd1, 2'd0})
                begin
                    n_bad++;
                    $display("FAIL rstmid c11: got v=%b st=%0d a=%0d b=%0d tw=%0d want 1/0/0/1/0",
                             valid, stage, addr_a, addr_b, tw_idx);
                end
            end
            next_cycle();
        end
        start = 1'b0;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_no_drain;
        int   s, off;
        logic ev, ed;
        for (int c = 0; c <= 14; c++) begin
            start0 = (c == 0);
            @(negedge clk);
            ev = (c >= 1 && c <= 12);
            ed = (c == 13);
            s = 0; off = 0;
            if (ev) begin
                s   = (c - 1) / 4;
                off = (c - 1) % 4;
            end
            n_cmp++;
            if ({valid0, done0, busy0} !== {ev, ed, (c >= 1 && c <= 13)}) begin
                n_bad++;
                $display("FAIL lat0 c%0d v/d/b: got %b want %b", c, {valid0, done0, busy0},
                         {ev, ed, (c >= 1 && c <= 13)});
            end
            if (ev) begin
                n_cmp++;
                if ({addr_a0, addr_b0, tw_idx0} !== {ta[s][off], tb_[s][off], ttw[s][off]}) begin
                    n_bad++;
                    $display("FAIL lat0 c%0d a/b/tw: got %0d/%0d/%0d want %0d/%0d/%0d", c,
                             addr_a0, addr_b0, tw_idx0, ta[s][off], tb_[s][off], ttw[s][off]);
                end
            end
            next_cycle();
        end
        start0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence(1'b0, 1'b0, "fwd");
        test_sequence(1'b1, 1'b0, "inv");
        test_stall();
        test_sequence(1'b0, 1'b1, "busy_start");
        test_reset_mid();
        test_no_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
